band_energy_scheduler: RTL and testbench



---
 rtl/band_energy_pkg.sv | 24 ++
 rtl/band_sq_acc.sv | 21 ++
 rtl/band_energy_scheduler.sv | 113 +++++++++++
 tb/tb_band_energy_scheduler.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/band_energy_pkg.sv
// Shared constants and FSM encoding for the band energy scheduler.
// One shared squarer/accumulator is time-multiplexed over all bands.
package band_energy_pkg;

    localparam int NUM_BINS          = 10;
    localparam int IN_W              = 12;
    localparam int ACC_W             = 34;
    localparam int OUT_W             = 12;
    localparam int SHIFT             = 22;
    localparam int DEFAULT_PRESCALER = 1900;

    localparam int PS_W      = 16;
    localparam int IDX_W     = $clog2(NUM_BINS);
    localparam int IN_BUS_W  = NUM_BINS * IN_W;
    localparam int OUT_BUS_W = NUM_BINS * OUT_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_CHECK,
        S_DUMP
    } state_t;

endpackage

// File: rtl/band_sq_acc.sv
// Shared squarer and saturating accumulator adder.
// The square of a signed sample is always non-negative, so it adds unsigned.
module band_sq_acc
    import band_energy_pkg::*;
(
    input  logic signed [IN_W-1:0]  x,
    input  logic        [ACC_W-1:0] acc_in,
    output logic        [ACC_W-1:0] acc_out
);

    logic signed [2*IN_W-1:0] sq_s;
    logic        [ACC_W:0]    sum;

    // square, widen, add, clamp at all-ones instead of wrapping
    always_comb begin
        sq_s    = x * x;
        sum     = {1'b0, acc_in} + (ACC_W+1)'($unsigned(sq_s));
        acc_out = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
    end

endmodule

// File: rtl/band_energy_scheduler.sv
// Per-band energy over a programmable window of samples.
// Publishes saturated energies and a one-cycle flag at each window end.
module band_energy_scheduler
    import band_energy_pkg::*;
#(
    parameter int SHIFT_AMT = SHIFT
) (
    input  logic                 vga_clk,
    input  logic                 rst_n,
    input  logic                 sample_valid,
    input  logic [IN_BUS_W-1:0]  band_samples,
    input  logic [PS_W-1:0]      prescaler_in,
    input  logic                 prescaler_load,
    output logic [PS_W-1:0]      prescaler,
    output logic [OUT_BUS_W-1:0] bin_energy,
    output logic                 set_values_flag,
    output logic                 busy,
    output logic                 sample_overrun
);

    state_t              state;
    state_t              state_nx;
    logic [IN_BUS_W-1:0] snap;
    logic [ACC_W-1:0]    acc [NUM_BINS];
    logic [ACC_W-1:0]    acc_upd;
    logic [IDX_W-1:0]    idx;
    logic [PS_W-1:0]     count;
    logic [PS_W-1:0]     shadow;
    logic [PS_W-1:0]     ps_eff;
    logic [PS_W:0]       cnt_inc;
    logic                win_end;

    function automatic logic [OUT_W-1:0] sat_out(input logic [ACC_W-1:0] a);
        logic [ACC_W-1:0] s;
        s = a >> SHIFT_AMT;
        return (|s[ACC_W-1:OUT_W]) ? '1 : s[OUT_W-1:0];
    endfunction

    // a zero window length behaves as one sample
    assign ps_eff  = (prescaler == '0) ? PS_W'(1) : prescaler;
    assign cnt_inc = {1'b0, count} + 1'b1;
    assign win_end = cnt_inc >= {1'b0, ps_eff};

    band_sq_acc u_sq_acc (
        .x      (snap[IN_W-1:0]),
        .acc_in (acc[idx]),
        .acc_out(acc_upd)
    );

    // state register
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // next state and status outputs
    always_comb begin
        state_nx       = state;
        busy           = (state != S_IDLE);
        sample_overrun = sample_valid && (state != S_IDLE);
        unique case (state)
            S_IDLE:  if (sample_valid) state_nx = S_MAC;
            S_MAC:   if (idx == IDX_W'(NUM_BINS-1)) state_nx = S_CHECK;
            S_CHECK: state_nx = win_end ? S_DUMP : S_IDLE;
            S_DUMP:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // datapath: snapshot, per-bin accumulate, window count, publish
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            snap            <= '0;
            idx             <= '0;
            count           <= '0;
            shadow          <= PS_W'(DEFAULT_PRESCALER);
            prescaler       <= PS_W'(DEFAULT_PRESCALER);
            bin_energy      <= '0;
            set_values_flag <= 1'b0;
            for (int i = 0; i < NUM_BINS; i++) acc[i] <= '0;
        end else begin
            set_values_flag <= 1'b0;
            if (prescaler_load) shadow <= prescaler_in;
            unique case (state)
                S_IDLE: begin
                    if (sample_valid) begin
                        snap <= band_samples;
                        idx  <= '0;
                    end
                end
                S_MAC: begin
                    acc[idx] <= acc_upd;
                    snap     <= snap >> IN_W;
                    idx      <= idx + 1'b1;
                end
                S_CHECK: begin
                    if (!win_end) count <= cnt_inc[PS_W-1:0];
                end
                S_DUMP: begin
                    for (int i = 0; i < NUM_BINS; i++) begin
                        bin_energy[i*OUT_W +: OUT_W] <= sat_out(acc[i]);
                        acc[i] <= '0;
                    end
                    count           <= '0;
                    set_values_flag <= 1'b1;
                    prescaler       <= shadow;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_band_energy_scheduler.sv
// Directed bench for band_energy_scheduler with SHIFT reduced to 10.
// Expected energies are hand-computed; flag timing is checked per sample.
module tb_band_energy_scheduler;
    import band_energy_pkg::*;

    logic                 vga_clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 sample_valid = 1'b0;
    logic [IN_BUS_W-1:0]  band_samples = '0;
    logic [PS_W-1:0]      prescaler_in = '0;
    logic                 prescaler_load = 1'b0;
    logic [PS_W-1:0]      prescaler;
    logic [OUT_BUS_W-1:0] bin_energy;
    logic                 set_values_flag;
    logic                 busy;
    logic                 sample_overrun;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int s0;
        int s1;
        int exp;
    } vec_t;

    vec_t tbl[8];

    band_energy_scheduler #(.SHIFT_AMT(10)) dut (
        .vga_clk        (vga_clk),
        .rst_n          (rst_n),
        .sample_valid   (sample_valid),
        .band_samples   (band_samples),
        .prescaler_in   (prescaler_in),
        .prescaler_load (prescaler_load),
        .prescaler      (prescaler),
        .bin_energy     (bin_energy),
        .set_values_flag(set_values_flag),
        .busy           (busy),
        .sample_overrun (sample_overrun)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [IN_BUS_W-1:0] mk(input int s, input bit alt);
        logic [IN_BUS_W-1:0] r;
        int v;
        r = '0;
        for (int k = 0; k < NUM_BINS; k++) begin
            v = (alt && (k % 2 == 1)) ? -s : s;
            r[k*IN_W +: IN_W] = v[IN_W-1:0];
        end
        return r;
    endfunction

    // strobe one sample at cycle T, watch cycles T+1..T+14;
    // off = cycle offset of the flag, -1 if none, -2 if more than one
    task automatic send(input logic [IN_BUS_W-1:0] bs, output int off);
        off = -1;
        @(negedge vga_clk);
        sample_valid = 1'b1;
        band_samples = bs;
        @(posedge vga_clk);
        #1;
        sample_valid = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            if (set_values_flag) off = (off == -1) ? k : -2;
            @(posedge vga_clk);
            #1;
        end
    endtask

    task automatic load_ps(input int v);
        @(negedge vga_clk);
        prescaler_in   = v[PS_W-1:0];
        prescaler_load = 1'b1;
        @(negedge vga_clk);
        prescaler_load = 1'b0;
    endtask

    task automatic run_n(input int n, input int s, output int flags);
        int off;
        flags = 0;
        for (int i = 0; i < n; i++) begin
            send(mk(s, 0), off);
            if (off != -1) flags++;
        end
    endtask

    task automatic check_bins(input string nm, input int exp);
        int bad;
        bad = -1;
        for (int k = 0; k < NUM_BINS; k++)
            if (int'(bin_energy[k*OUT_W +: OUT_W]) != exp && bad < 0) bad = k;
        chk(nm, (bad < 0) ? exp : int'(bin_energy[bad*OUT_W +: OUT_W]), exp);
    endtask

    initial begin
        int o1, o2, fl;
        logic [IN_BUS_W-1:0] bs;

        tbl[0] = '{64, 64, 8};
        tbl[1] = '{100, -100, 19};
        tbl[2] = '{-1000, 1000, 1953};
        tbl[3] = '{2047, 2047, 4095};
        tbl[4] = '{32, 0, 1};
        tbl[5] = '{31, 0, 0};
        tbl[6] = '{-1448, -1448, 4095};
        tbl[7] = '{-1449, -1449, 4095};

        repeat (3) @(posedge vga_clk);
        @(negedge vga_clk);
        rst_n = 1'b1;
        repeat (2) @(posedge vga_clk);
        #1;
        chk("rst_prescaler", prescaler, 1900);
        chk("rst_energy", bin_energy, 0);
        chk("rst_busy", busy, 0);
        chk("rst_flag", set_values_flag, 0);
        chk("rst_overrun", sample_overrun, 0);

        // first window runs at the reset length
        load_ps(2);
        run_n(1899, 0, fl);
        chk("win1900_early_flags", fl, 0);
        send(mk(0, 0), o2);
        chk("win1900_flag_off", o2, 13);
        chk("ps_after_first_dump", prescaler, 2);
        check_bins("win1900_energy", 0);

        for (int i = 0; i < 8; i++) begin
            send(mk(tbl[i].s0, 1), o1);
            send(mk(tbl[i].s1, 0), o2);
            chk($sformatf("tbl%0d_no_early_flag", i), o1, -1);
            chk($sformatf("tbl%0d_flag_off", i), o2, 13);
            check_bins($sformatf("tbl%0d_energy", i), tbl[i].exp);
        end

        // distinct per-bin values to check bin ordering
        bs = '0;
        for (int k = 0; k < NUM_BINS; k++) begin
            o1 = 32 * (k + 1);
            bs[k*IN_W +: IN_W] = o1[IN_W-1:0];
        end
        send(bs, o1);
        send(mk(0, 0), o2);
        chk("order_flag_off", o2, 13);
        for (int k = 0; k < NUM_BINS; k++)
            chk($sformatf("order_bin%0d", k),
                bin_energy[k*OUT_W +: OUT_W], (k + 1) * (k + 1));

        // saturation, then cleared accumulators
        load_ps(4);
        run_n(2, 0, fl);
        chk("ps4_flags", fl, 1);
        chk("ps4_value", prescaler, 4);
        run_n(3, -2048, fl);
        send(mk(-2048, 0), o2);
        chk("sat_early_flags", fl, 0);
        chk("sat_flag_off", o2, 13);
        check_bins("sat_energy", 4095);
        run_n(3, 64, fl);
        send(mk(64, 0), o2);
        chk("clear_flag_off", o2, 13);
        check_bins("clear_energy", 16);

        // dropped sample while busy
        load_ps(2);
        run_n(4, 0, fl);
        chk("ps2_value", prescaler, 2);
        @(negedge vga_clk);
        sample_valid = 1'b1;
        band_samples = mk(5, 0);
        @(posedge vga_clk);
        #1;
        sample_valid = 1'b0;
        @(posedge vga_clk);
        #1;
        @(posedge vga_clk);
        #1;
        sample_valid = 1'b1;
        #1;
        chk("ovr_pulse", sample_overrun, 1);
        chk("ovr_busy", busy, 1);
        @(posedge vga_clk);
        #1;
        sample_valid = 1'b0;
        #1;
        chk("ovr_one_cycle", sample_overrun, 0);
        fl = 0;
        for (int k = 0; k < 14; k++) begin
            if (set_values_flag) fl++;
            @(posedge vga_clk);
            #1;
        end
        chk("ovr_not_counted", fl, 0);
        send(mk(0, 0), o2);
        chk("ovr_next_flag_off", o2, 13);

        // shadow load mid-window takes effect at the next dump
        load_ps(3);
        run_n(2, 0, fl);
        chk("ps3_value", prescaler, 3);
        send(mk(64, 0), o1);
        load_ps(5);
        chk("ps_held_mid_window", prescaler, 3);
        run_n(1, 64, fl);
        send(mk(64, 0), o2);
        chk("ps3_window_flags", ((o1 == -1) && (fl == 0)) ? 1 : 0, 1);
        chk("ps3_window_flag_off", o2, 13);
        chk("ps5_after_flag", prescaler, 5);
        check_bins("ps3_energy", 12);
        run_n(4, 64, fl);
        send(mk(64, 0), o2);
        chk("ps5_early_flags", fl, 0);
        chk("ps5_flag_off", o2, 13);
        check_bins("ps5_energy", 20);

        // reset during MAC of sample 2
        send(mk(0, 0), o1);
        chk("pre_rst_no_flag", o1, -1);
        @(negedge vga_clk);
        sample_valid = 1'b1;
        band_samples = mk(64, 0);
        @(posedge vga_clk);
        #1;
        sample_valid = 1'b0;
        @(posedge vga_clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_prescaler", prescaler, 1900);
        chk("midrst_energy", bin_energy, 0);
        chk("midrst_flag", set_values_flag, 0);
        @(negedge vga_clk);
        rst_n = 1'b1;
        run_n(1899, 0, fl);
        chk("postrst_early_flags", fl, 0);
        send(mk(0, 0), o2);
        chk("postrst_flag_off", o2, 13);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
